plaintext_streamer: RTL and testbench

PLAINTEXT_STREAMER -- requirements
Module: plaintext_streamer

---
 rtl/plaintext_streamer.sv | 159 +++++++++++++++
 tb/tb_plaintext_streamer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/plaintext_streamer.sv
// Streams the decrypted message out of the RAM once the cracking core terminates:
// one byte per ADDR -> WAIT -> PRESENT pass, then reports done/fail until terminated drops.
`timescale 1ns/1ps
module plaintext_streamer #(
  parameter int RAM_WIDTH          = 8,
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5,
  parameter int KEY_WIDTH          = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          terminated,
  input  logic                          succeeded,
  input  logic [KEY_WIDTH-1:0]          found_key,
  output logic [MESSAGE_LOG_LENGTH-1:0] aAddr,
  input  logic [RAM_WIDTH-1:0]          aOut,
  output logic [RAM_WIDTH-1:0]          dData,
  output logic                          dValid,
  input  logic                          dReady,
  output logic                          dLast,
  output logic [KEY_WIDTH-1:0]          key_out,
  output logic                          done,
  output logic                          fail
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4,
    FAIL    = 3'd5
  } state_t;

  localparam logic [MESSAGE_LOG_LENGTH-1:0] LAST_IDX = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);
  localparam logic [MESSAGE_LOG_LENGTH-1:0] ONE_IDX  = MESSAGE_LOG_LENGTH'(1);

  state_t                        state_q, state_d;
  logic [MESSAGE_LOG_LENGTH-1:0] cnt_q, cnt_d;
  logic                          term_q, term_d;
  logic [MESSAGE_LOG_LENGTH-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]          data_q, data_d;
  logic                          valid_q, valid_d;
  logic                          last_q, last_d;
  logic [KEY_WIDTH-1:0]          key_q, key_d;
  logic                          done_q, done_d;
  logic                          fail_q, fail_d;

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    term_d  = terminated;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    key_d   = key_q;
    done_d  = done_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        // Only a fresh rising edge of terminated starts a session.
        if (terminated && !term_q) begin
          key_d = found_key;
          if (succeeded) begin
            state_d = ADDR;
            cnt_d   = '0;
            addr_d  = '0;
          end else begin
            state_d = FAIL;
            done_d  = 1'b1;
            fail_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        state_d = WAIT;
      end
      WAIT: begin
        data_d  = aOut;
        valid_d = 1'b1;
        last_d  = (cnt_q == LAST_IDX);
        state_d = PRESENT;
      end
      PRESENT: begin
        if (dReady) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
            fail_d  = 1'b0;
          end else begin
            cnt_d   = cnt_q + ONE_IDX;
            addr_d  = cnt_q + ONE_IDX;
            state_d = ADDR;
          end
        end else begin
          state_d = PRESENT;
        end
      end
      DONE, FAIL: begin
        if (!terminated) begin
          state_d = IDLE;
          done_d  = 1'b0;
          fail_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        fail_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      term_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      key_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      key_q   <= key_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign aAddr   = addr_q;
  assign dData   = data_q;
  assign dValid  = valid_q;
  assign dLast   = last_q;
  assign key_out = key_q;
  assign done    = done_q;
  assign fail    = fail_q;

endmodule

// File: tb/tb_plaintext_streamer.sv
// Directed bench for plaintext_streamer: a RAM model feeds the streamer and a
// scoreboard of expected {dLast, byte} pairs is checked at every transfer.
`timescale 1ns/1ps
module tb_plaintext_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        terminated;
  logic        succeeded;
  logic [23:0] found_key;
  logic [4:0]  aAddr;
  logic [7:0]  aOut;
  logic [7:0]  dData;
  logic        dValid;
  logic        dReady;
  logic        dLast;
  logic [23:0] key_out;
  logic        done;
  logic        fail;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int valid_cnt = 0;

  logic [8:0] sb[$];
  logic [7:0] ram[32];

  logic       prev_hold = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always #5 clk = ~clk;

  plaintext_streamer dut (
    .clk(clk), .reset(reset), .terminated(terminated), .succeeded(succeeded),
    .found_key(found_key), .aAddr(aAddr), .aOut(aOut), .dData(dData),
    .dValid(dValid), .dReady(dReady), .dLast(dLast), .key_out(key_out),
    .done(done), .fail(fail)
  );

  // Synchronous-read RAM: data appears one cycle after the address.
  always @(posedge clk) aOut <= ram[aAddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_msg();
    sb.delete();
    for (int i = 0; i < 32; i++) sb.push_back({(i == 31), 8'(8'h41 + i)});
  endtask

  // Skips the trigger edge, then counts edges until done (bounded).
  task automatic wait_done(input bit rnd, output int n);
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 3000) begin
      if (rnd) dReady = ($urandom_range(0, 9) < 3);
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
    dReady = 1'b1;
  endtask

  task automatic cycles(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // Transfer monitor and hold-stability checker.
  always @(negedge clk) begin
    if (!reset) begin
      if (dValid) valid_cnt++;
      if (prev_hold) begin
        chk("hold_valid", {31'd0, dValid}, 32'd1);
        chk("hold_data", {24'd0, dData}, {24'd0, prev_data});
        chk("hold_last", {31'd0, dLast}, {31'd0, prev_last});
      end
      prev_hold = dValid && !dReady;
      prev_data = dData;
      prev_last = dLast;
      if (dValid && dReady) begin
        xfer_cnt++;
        chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) chk("xfer_byte", {23'd0, dLast, dData}, {23'd0, sb.pop_front()});
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    int n;
    int vc;
    for (int i = 0; i < 32; i++) ram[i] = 8'(8'h41 + i);
    reset = 1'b1; terminated = 1'b0; succeeded = 1'b0; found_key = 24'h0; dReady = 1'b1;
    cycles(3);
    chk("rst_aAddr", {27'd0, aAddr}, 32'd0);
    chk("rst_dValid", {31'd0, dValid}, 32'd0);
    chk("rst_dData", {24'd0, dData}, 32'd0);
    chk("rst_dLast", {31'd0, dLast}, 32'd0);
    chk("rst_key", {8'd0, key_out}, 32'd0);
    chk("rst_done_fail", {30'd0, done, fail}, 32'd0);
    reset = 1'b0;
    cycles(2);

    // Nominal stream with sink always ready.
    push_msg(); xfer_cnt = 0;
    found_key = 24'h490200; succeeded = 1'b1; terminated = 1'b1;
    wait_done(1'b0, n);
    chk("trig_to_done_cycles", n, 32'd96);
    chk("s1_xfers", xfer_cnt, 32'd32);
    chk("s1_sb_empty", sb.size(), 32'd0);
    chk("s1_key", {8'd0, key_out}, 32'h490200);
    chk("s1_fail", {31'd0, fail}, 32'd0);
    chk("s1_dValid_in_done", {31'd0, dValid}, 32'd0);
    terminated = 1'b0;
    cycles(2);
    chk("s1_clear", {30'd0, done, fail}, 32'd0);

    // Failed crack: done/fail the cycle after trigger, never any valid byte.
    vc = valid_cnt;
    succeeded = 1'b0; found_key = 24'h123456; terminated = 1'b1;
    cycles(2);
    chk("fail_done_fail", {30'd0, done, fail}, 32'd3);
    chk("fail_key", {8'd0, key_out}, 32'h123456);
    cycles(4);
    chk("fail_no_valid", valid_cnt, vc);
    terminated = 1'b0;
    cycles(1);
    chk("fail_clear", {30'd0, done, fail}, 32'd0);
    cycles(2);

    // Back-pressured stream with ~30% ready duty.
    push_msg(); xfer_cnt = 0;
    found_key = 24'h490200; succeeded = 1'b1; terminated = 1'b1;
    wait_done(1'b1, n);
    chk("s3_xfers", xfer_cnt, 32'd32);
    chk("s3_sb_empty", sb.size(), 32'd0);
    chk("s3_fail", {31'd0, fail}, 32'd0);
    terminated = 1'b0;
    cycles(2);

    // Reset while byte 10 is being presented; terminated held high.
    push_msg(); xfer_cnt = 0;
    terminated = 1'b1;
    n = 0;
    while (xfer_cnt < 10 && n < 200) begin @(posedge clk); #1; n++; end
    dReady = 1'b0;
    n = 0;
    while (!dValid && n < 20) begin @(posedge clk); #1; n++; end
    chk("byte10_presented", {23'd0, dValid, dData}, {23'd0, 1'b1, 8'h4B});
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_outputs", {dValid, dLast, done, fail, aAddr, dData}, 32'd0);
      chk("midrst_key", {8'd0, key_out}, 32'd0);
    end
    push_msg(); xfer_cnt = 0;
    dReady = 1'b1;
    reset = 1'b0;
    wait_done(1'b0, n);
    chk("restart_cycles", n, 32'd96);
    chk("restart_xfers", xfer_cnt, 32'd32);
    chk("restart_sb_empty", sb.size(), 32'd0);
    terminated = 1'b0;
    cycles(2);

    // Inputs disturbed mid-stream must not affect the session.
    push_msg(); xfer_cnt = 0;
    found_key = 24'h490200; succeeded = 1'b1; terminated = 1'b1;
    n = 0;
    while (xfer_cnt < 5 && n < 200) begin @(posedge clk); #1; n++; end
    found_key = 24'h000001; succeeded = 1'b0; terminated = 1'b0;
    cycles(1);
    terminated = 1'b1;
    cycles(3);
    succeeded = 1'b1;
    n = 0;
    while (!done && n < 300) begin @(posedge clk); #1; n++; end
    chk("s5_done", {31'd0, done}, 32'd1);
    chk("s5_xfers", xfer_cnt, 32'd32);
    chk("s5_sb_empty", sb.size(), 32'd0);
    chk("s5_key", {8'd0, key_out}, 32'h490200);
    chk("s5_fail", {31'd0, fail}, 32'd0);
    terminated = 1'b0;
    cycles(2);
    vc = valid_cnt;
    cycles(8);
    chk("s5_no_second_session", valid_cnt, vc);
    chk("s5_idle", {30'd0, done, fail}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
